// File: rtl/obi_ram_port.sv
// -----------------------------------------------------------------------------
// obi_ram_port
//
// Upstream adapter between a core-side OBI-style request/grant/rvalid bus and
// one port of the byte-enabled SRAM. The SRAM returns read data exactly one
// cycle after ram_en_o, so the block keeps a one-deep "in flight" stage and a
// small response FIFO that absorbs responses while the consumer stalls.
// Responses leave in request order.
//
// Optional feature macro: OBI_RAM_ERR_EN
//   defined   : out-of-range word addresses (>= MEM_WORDS) and writes with no
//               byte enables are answered with err_o=1 and never reach the SRAM
//   undefined : no checks, every accepted request goes to the SRAM with the
//               word address truncated to ADDR_WIDTH; err_o is always 0
//
// Ports
//   clk, rst_ni       clock (rising edge), asynchronous active-low reset
//   req_i / gnt_o     request handshake; gnt_o is combinational
//   addr_i            byte address, bits [1:0] ignored
//   we_i, be_i        write enable, byte enables
//   wdata_i           write data
//   rvalid_o/rready_i response handshake
//   rdata_o, err_o    response payload
//   ram_*_o           SRAM strobes, driven combinationally in the accept cycle
//   ram_rdata_i       SRAM read data, valid the cycle after ram_en_o
// -----------------------------------------------------------------------------
module obi_ram_port #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned NUM_COL    = 4,
    parameter int unsigned COL_WIDTH  = 8,
    parameter int unsigned DATA_WIDTH = NUM_COL * COL_WIDTH,
    parameter int unsigned MEM_WORDS  = 1024,
    parameter int unsigned RSP_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_ni,
    input  logic                  req_i,
    output logic                  gnt_o,
    input  logic [ADDR_WIDTH+1:0] addr_i,
    input  logic                  we_i,
    input  logic [NUM_COL-1:0]    be_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  rvalid_o,
    input  logic                  rready_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  err_o,
    output logic                  ram_en_o,
    output logic                  ram_we_o,
    output logic [NUM_COL-1:0]    ram_be_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [DATA_WIDTH-1:0] ram_wdata_o,
    input  logic [DATA_WIDTH-1:0] ram_rdata_i
);

    localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);

    logic [ADDR_WIDTH-1:0] word_addr;
    logic                  accept;
    logic                  acc_err;

    logic                  inflight_q;
    logic                  infl_err_q;
    logic                  infl_we_q;

    logic [DATA_WIDTH-1:0] pay_data;
    logic                  pay_err;

    logic [DATA_WIDTH-1:0] fifo_data [RSP_DEPTH];
    logic                  fifo_err  [RSP_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [CNT_W-1:0]      fifo_cnt_q;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;
    logic [CNT_W-1:0]      outstanding;

    logic                  unused_addr_lsb;

    assign unused_addr_lsb = ^addr_i[1:0];
    assign word_addr       = addr_i[ADDR_WIDTH+1:2];

    // ---------------------------------------------------------------- request
    // Credit counts both the in-flight access and buffered responses; a pop in
    // the current cycle does not free a slot until the next cycle.
    assign outstanding = CNT_W'(inflight_q) + fifo_cnt_q;
    assign gnt_o       = req_i & (outstanding < CNT_W'(RSP_DEPTH));
    assign accept      = req_i & gnt_o;

`ifdef OBI_RAM_ERR_EN
    assign acc_err = ({1'b0, word_addr} >= (ADDR_WIDTH+1)'(MEM_WORDS))
                   | (we_i & (be_i == '0));
`else
    localparam int unsigned unused_mem_words = MEM_WORDS;
    assign acc_err = 1'b0;
`endif

    assign ram_en_o    = accept & ~acc_err;
    assign ram_we_o    = ram_en_o & we_i;
    assign ram_be_o    = ram_en_o ? be_i : '0;
    assign ram_addr_o  = word_addr;
    assign ram_wdata_o = wdata_i;

    // ------------------------------------------------------------ stage reg
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            inflight_q <= 1'b0;
            infl_err_q <= 1'b0;
            infl_we_q  <= 1'b0;
        end else begin
            inflight_q <= accept;
            infl_err_q <= accept & acc_err;
            infl_we_q  <= accept & we_i;
        end
    end

    // Payload of the access issued last cycle; only reads carry SRAM data.
    assign pay_err  = infl_err_q;
    assign pay_data = (infl_err_q | infl_we_q) ? '0 : ram_rdata_i;

    // ----------------------------------------------------------- resp FIFO
    assign fifo_empty = (fifo_cnt_q == '0);
    assign pop        = ~fifo_empty & rready_i;
    // Once something is buffered the in-flight payload must queue behind it to
    // keep order, even if the consumer is ready.
    assign push       = inflight_q & (~fifo_empty | ~rready_i);

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == PTR_W'(RSP_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(RSP_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
                2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr_q] <= pay_data;
            fifo_err[wr_ptr_q]  <= pay_err;
        end
    end

    // --------------------------------------------------------------- output
    always_comb begin
        rvalid_o = 1'b0;
        rdata_o  = '0;
        err_o    = 1'b0;
        if (!fifo_empty) begin
            rvalid_o = 1'b1;
            rdata_o  = fifo_data[rd_ptr_q];
            err_o    = fifo_err[rd_ptr_q];
        end else if (inflight_q) begin
            rvalid_o = 1'b1;
            rdata_o  = pay_data;
            err_o    = pay_err;
        end
    end

endmodule

// File: tb/tb_obi_ram_port.sv
module tb_obi_ram_port;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;
`ifdef OBI_RAM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk;
    logic          rst_ni;
    logic          req_i;
    logic          gnt_o;
    logic [AW+1:0] addr_i;
    logic          we_i;
    logic [3:0]    be_i;
    logic [DW-1:0] wdata_i;
    logic          rvalid_o;
    logic          rready_i;
    logic [DW-1:0] rdata_o;
    logic          err_o;
    logic          ram_en_o;
    logic          ram_we_o;
    logic [3:0]    ram_be_o;
    logic [AW-1:0] ram_addr_o;
    logic [DW-1:0] ram_wdata_o;
    logic [DW-1:0] ram_rdata_i;

    int n_tests = 0;
    int n_fail  = 0;

    obi_ram_port #(
        .ADDR_WIDTH (AW),
        .NUM_COL    (4),
        .COL_WIDTH  (8),
        .DATA_WIDTH (DW),
        .MEM_WORDS  (512),
        .RSP_DEPTH  (2)
    ) dut (
        .clk         (clk),
        .rst_ni      (rst_ni),
        .req_i       (req_i),
        .gnt_o       (gnt_o),
        .addr_i      (addr_i),
        .we_i        (we_i),
        .be_i        (be_i),
        .wdata_i     (wdata_i),
        .rvalid_o    (rvalid_o),
        .rready_i    (rready_i),
        .rdata_o     (rdata_o),
        .err_o       (err_o),
        .ram_en_o    (ram_en_o),
        .ram_we_o    (ram_we_o),
        .ram_be_o    (ram_be_o),
        .ram_addr_o  (ram_addr_o),
        .ram_wdata_o (ram_wdata_o),
        .ram_rdata_i (ram_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM: byte-enabled write, 1-cycle read latency.
    logic [DW-1:0] mem [1024];
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        ram_rdata_i = '0;
    end
    always @(posedge clk) begin
        if (ram_en_o) begin
            if (ram_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (ram_be_o[b]) mem[ram_addr_o][b*8 +: 8] <= ram_wdata_o[b*8 +: 8];
            end else begin
                ram_rdata_i <= mem[ram_addr_o];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive at the falling edge, leave time for combinational settle, sample
    // before the next rising edge.
    task automatic drive(input logic req, input logic we, input logic [3:0] be,
                         input logic [AW+1:0] addr, input logic [31:0] wd, input logic rr);
        @(negedge clk);
        req_i = req; we_i = we; be_i = be; addr_i = addr; wdata_i = wd; rready_i = rr;
        #3;
    endtask

    typedef struct {
        logic          req;
        logic          we;
        logic [3:0]    be;
        logic [AW+1:0] addr;
        logic [31:0]   wdata;
        logic          gnt;
        logic          en;
        logic          rvalid;
        logic [31:0]   rdata;
        logic          err;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    function automatic vec_t mk(logic req, logic we, logic [3:0] be, logic [AW+1:0] addr,
                                logic [31:0] wd, logic gnt, logic en, logic rv,
                                logic [31:0] rd, logic err);
        vec_t v;
        v.req = req; v.we = we; v.be = be; v.addr = addr; v.wdata = wd;
        v.gnt = gnt; v.en = en; v.rvalid = rv; v.rdata = rd; v.err = err;
        return v;
    endfunction

    initial begin
        // Each row: request this cycle, and the response expected this cycle
        // (belonging to the previous row's request, rready held high).
        vecs[0]  = mk(1, 1, 4'hF, 12'h010, 32'hDEADBEEF, 1, 1,      0, 32'h0,        0);
        vecs[1]  = mk(1, 0, 4'h0, 12'h010, 32'h0,        1, 1,      1, 32'h0,        0);
        vecs[2]  = mk(1, 1, 4'h2, 12'h010, 32'h0000AA00, 1, 1,      1, 32'hDEADBEEF, 0);
        vecs[3]  = mk(1, 0, 4'h0, 12'h010, 32'h0,        1, 1,      1, 32'h0,        0);
        vecs[4]  = mk(0, 0, 4'h0, 12'h000, 32'h0,        0, 0,      1, 32'hDEADAAEF, 0);
        vecs[5]  = mk(1, 0, 4'h0, 12'h800, 32'h0,        1, !ERR_EN, 0, 32'h0,       0);
        vecs[6]  = mk(1, 1, 4'h0, 12'h010, 32'hFFFFFFFF, 1, !ERR_EN, 1, 32'h0,       ERR_EN);
        vecs[7]  = mk(1, 0, 4'h0, 12'h010, 32'h0,        1, 1,      1, 32'h0,        ERR_EN);
        vecs[8]  = mk(0, 0, 4'h0, 12'h000, 32'h0,        0, 0,      1, 32'hDEADAAEF, 0);
        vecs[9]  = mk(1, 1, 4'hF, 12'h014, 32'h11112222, 1, 1,      0, 32'h0,        0);
        vecs[10] = mk(1, 1, 4'hF, 12'h018, 32'h33334444, 1, 1,      1, 32'h0,        0);
        vecs[11] = mk(0, 0, 4'h0, 12'h000, 32'h0,        0, 0,      1, 32'h0,        0);
        vecs[12] = mk(0, 0, 4'h0, 12'h000, 32'h0,        0, 0,      0, 32'h0,        0);

        rst_ni = 1'b0; req_i = 0; we_i = 0; be_i = '0; addr_i = '0; wdata_i = '0; rready_i = 0;
        #2;
        chk("rst.gnt",    gnt_o,    0);
        chk("rst.rvalid", rvalid_o, 0);
        chk("rst.rdata",  rdata_o,  0);
        chk("rst.err",    err_o,    0);
        chk("rst.en",     ram_en_o, 0);
        chk("rst.we",     ram_we_o, 0);
        chk("rst.be",     ram_be_o, 0);
        @(negedge clk);
        rst_ni = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].req, vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata, 1'b1);
            chk($sformatf("v%0d.gnt", i),    gnt_o,    vecs[i].gnt);
            chk($sformatf("v%0d.en", i),     ram_en_o, vecs[i].en);
            chk($sformatf("v%0d.rvalid", i), rvalid_o, vecs[i].rvalid);
            if (vecs[i].rvalid) begin
                chk($sformatf("v%0d.rdata", i), rdata_o, vecs[i].rdata);
                chk($sformatf("v%0d.err", i),   err_o,   vecs[i].err);
            end
        end

        // Stall with a full response buffer, then release.
        drive(1, 0, 4'h0, 12'h010, 32'h0, 0);
        chk("st0.gnt", gnt_o, 1);    chk("st0.rvalid", rvalid_o, 0);
        drive(1, 0, 4'h0, 12'h014, 32'h0, 0);
        chk("st1.gnt", gnt_o, 1);    chk("st1.rvalid", rvalid_o, 1);
        chk("st1.rdata", rdata_o, 32'hDEADAAEF);
        drive(1, 0, 4'h0, 12'h018, 32'h0, 0);
        chk("st2.gnt", gnt_o, 0);    chk("st2.en", ram_en_o, 0);
        chk("st2.rdata", rdata_o, 32'hDEADAAEF);
        drive(1, 0, 4'h0, 12'h018, 32'h0, 0);
        chk("st3.gnt", gnt_o, 0);    chk("st3.rvalid", rvalid_o, 1);
        chk("st3.rdata", rdata_o, 32'hDEADAAEF);
        drive(1, 0, 4'h0, 12'h018, 32'h0, 1);
        chk("st4.gnt", gnt_o, 0);    chk("st4.rdata", rdata_o, 32'hDEADAAEF);
        drive(1, 0, 4'h0, 12'h018, 32'h0, 1);
        chk("st5.gnt", gnt_o, 1);    chk("st5.rdata", rdata_o, 32'h11112222);
        drive(0, 0, 4'h0, 12'h000, 32'h0, 1);
        chk("st6.rvalid", rvalid_o, 1); chk("st6.rdata", rdata_o, 32'h33334444);
        drive(0, 0, 4'h0, 12'h000, 32'h0, 1);
        chk("st7.rvalid", rvalid_o, 0);

        // Asynchronous reset with two responses buffered.
        drive(1, 0, 4'h0, 12'h010, 32'h0, 0);
        drive(1, 0, 4'h0, 12'h014, 32'h0, 0);
        drive(0, 0, 4'h0, 12'h000, 32'h0, 0);
        chk("rs0.rvalid", rvalid_o, 1);
        chk("rs0.rdata",  rdata_o,  32'hDEADAAEF);
        #1 rst_ni = 1'b0;
        #1;
        chk("rs1.rvalid", rvalid_o, 0);
        chk("rs1.rdata",  rdata_o,  0);
        chk("rs1.gnt",    gnt_o,    0);
        @(negedge clk);
        rst_ni = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 4'h0, 12'h000, 32'h0, 1);
            chk($sformatf("rs2_%0d.rvalid", k), rvalid_o, 0);
        end
        drive(1, 0, 4'h0, 12'h018, 32'h0, 1);
        chk("rs3.gnt", gnt_o, 1);   chk("rs3.en", ram_en_o, 1);
        drive(0, 0, 4'h0, 12'h000, 32'h0, 1);
        chk("rs4.gnt", gnt_o, 0);   chk("rs4.rvalid", rvalid_o, 1);
        chk("rs4.rdata", rdata_o, 32'h33334444);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
